pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
// Parametrised program-counter sequencer for the multi-cycle RISC-V core: the
// next generation of the PC update logic. Adds a configurable width and reset
// vector, a stall input, JALR bit-0 clearing, misaligned-target detection,
// trap entry through mtvec (direct/vectored) and mret return through mepc.
// Sits between decode/ALU and instruction fetch. Advances once per instruction,
// in the EXECUTE state.
// PARAMETERS
// XLEN         32   datapath/address width
// STATE_W      4    width of core FSM state bus
// EXEC_STATE   4    state encoding in which PC commits
// RESET_VECTOR 0    PC value after reset
// MTVEC_RESET  0    mtvec value after reset
// PORTS
// clk          in   1        clock
// rst          in   1        synchronous, active-high reset
// state        in   STATE_W  core FSM state
// stall        in   1        1 = suppress commit this cycle
// is_btype/is_jal/is_jalr in 1 each  decoded control-transfer class (one-hot or none)
// take_branch  in   1        branch condition result
// imm_b/imm_j/imm_u in XLEN  sign-extended immediates
// alu_result   in   XLEN     rs1+imm for JALR
// trap_req     in   1        take trap this commit
// trap_is_irq  in   1        1 = interrupt, 0 = synchronous exception
// trap_cause   in   5        cause code
// mret         in   1        return from trap
// mtvec_wr     in   1        write mtvec
// mtvec_wdata  in   XLEN     mtvec write data
// pc           out  XLEN     current PC
// pc_plus_4    out  XLEN     pc+4 (comb)
// pc_plus_imm  out  XLEN     pc+(imm_b|imm_j|imm_u by class) (comb)
// mepc/mcause/mtvec out XLEN  trap CSRs
// misalign_exc out  1        1-cycle pulse on misaligned-target trap
// BEHAVIOUR
// - Reset: pc=RESET_VECTOR, mepc=0, mcause=0, mtvec=MTVEC_RESET, misalign_exc=0.
//   rst has priority over everything, including a concurrent commit.
// - Commit = (state==EXEC_STATE) & !stall & !rst. Non-commit cycles hold pc/mepc/mcause.
// - Normal target: (is_btype&take_branch)|is_jal -> pc_plus_imm;
//   is_jalr -> {alu_result[XLEN-1:1],1'b0}; else pc_plus_4. All adds wrap mod 2^XLEN.
// - Commit priority: trap_req > mret > misaligned normal target > normal target.
//   trap_req is sampled only when commit=1.
//   * trap_req: mcause={trap_is_irq,(XLEN-6)'b0,trap_cause}.
//     - Interrupt: mepc=normal target.
//     - Exception: mepc=pc.
//     - pc = base = {mtvec[XLEN-1:2],2'b00}.
//     - If mtvec[0]=1 & trap_is_irq: pc = base + 4*trap_cause.
//   * mret: pc={mepc[XLEN-1:2],2'b00}. mepc/mcause unchanged.
//   * Misaligned: applies when the normal target[1:0]!=0 and the instruction
//     is taken-branch/JAL/JALR. Result: mepc=pc, mcause=0, pc=base,
//     misalign_exc=1 for exactly the next cycle.
// - mtvec_wr: accepted in any non-reset cycle. mtvec={wdata[XLEN-1:2],1'b0,wdata[0]}.
//   A concurrent trap uses the OLD mtvec.
// - Latency: pc updates on the clock edge closing the commit cycle.
//   pc_plus_4 and pc_plus_imm are combinational from the current pc.
// TESTING
// 1. rst=1 for 2 cycles with RESET_VECTOR=0x100 -> pc=0x100, mepc=mcause=0, misalign_exc=0.
// 2. pc=0x200, is_btype, take_branch=1, imm_b=0x10, commit -> pc=0x210.
//    Same with stall=1 -> pc holds 0x200.
// 3. pc=0x300, is_jalr, alu_result=0x401 -> pc=0x400.
//    Separately: is_jal, imm_j=0x6 -> pc=mtvec base, mepc=0x300, mcause=0, misalign_exc pulses 1 cycle.
// 4. mtvec=0x1001 (vectored), trap_req, trap_is_irq=1, trap_cause=7, pc=0x500, no branch
//    -> pc=0x101C, mepc=0x504, mcause=0x80000007.
//    Same with trap_is_irq=0 -> pc=0x1000, mepc=0x500.
// 5. After test 4 (interrupt case), mret at commit -> pc=0x504.
//    mtvec_wr=1 with wdata=0x2000, asserted in the same cycle as trap_req -> trap
//    targets the old mtvec; mtvec reads 0x2000 afterwards.
// 6. rst asserted in the same cycle as a commit with trap_req -> pc=RESET_VECTOR; CSRs reset.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC update with JALR alignment, misalign trap, mtvec trap entry and mret return
module pc_sequencer #(
  parameter int XLEN = 32,
  parameter int STATE_W = 4,
  parameter logic [STATE_W-1:0] EXEC_STATE = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic               stall,
  input  logic               is_btype,
  input  logic               is_jal,
  input  logic               is_jalr,
  input  logic               take_branch,
  input  logic [XLEN-1:0]    imm_b,
  input  logic [XLEN-1:0]    imm_j,
  input  logic [XLEN-1:0]    imm_u,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               trap_req,
  input  logic               trap_is_irq,
  input  logic [4:0]         trap_cause,
  input  logic               mret,
  input  logic               mtvec_wr,
  input  logic [XLEN-1:0]    mtvec_wdata,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus_4,
  output logic [XLEN-1:0]    pc_plus_imm,
  output logic [XLEN-1:0]    mepc,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mtvec,
  output logic               misalign_exc
);
  logic commit, taken, misal;
  logic [XLEN-1:0] nt, base, trap_pc;
  always_comb begin
    commit = (state == EXEC_STATE) && !stall;
    taken = (is_btype && take_branch) || is_jal;
    pc_plus_4 = pc + XLEN'(4);
    pc_plus_imm = pc + (is_btype ? imm_b : is_jal ? imm_j : imm_u);
    nt = is_jalr ? (alu_result & ~XLEN'(1)) : taken ? pc_plus_imm : pc_plus_4;
    misal = (taken || is_jalr) && (nt[1:0] != 2'b00);
    base = mtvec & ~XLEN'(3);
    trap_pc = (mtvec[0] && trap_is_irq) ? base + XLEN'({trap_cause, 2'b00}) : base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      mepc <= '0;
      mcause <= '0;
      mtvec <= MTVEC_RESET;
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= commit && !trap_req && !mret && misal;
      if (mtvec_wr) mtvec <= mtvec_wdata & ~XLEN'(2);
      if (commit) begin
        if (trap_req) begin
          pc <= trap_pc;
          mepc <= trap_is_irq ? nt : pc;
          mcause <= {trap_is_irq, {(XLEN-6){1'b0}}, trap_cause};
        end else if (mret) begin
          pc <= mepc & ~XLEN'(3);
        end else if (misal) begin
          pc <= base;
          mepc <= pc;
          mcause <= '0;
        end else begin
          pc <= nt;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized run against a behavioural model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst, stall, btype, jal, jalr, take, trap, irq, mret, wr;
  logic [3:0] state;
  logic [4:0] cause;
  logic [31:0] imm_b, imm_j, imm_u, alu, wdata;
  logic [31:0] pc, pc_plus_4, pc_plus_imm, mepc, mcause, mtvec;
  logic mis;
  int n_cmp = 0, n_bad = 0;

  pc_sequencer #(.XLEN(32), .STATE_W(4), .EXEC_STATE(4), .RESET_VECTOR(32'h100), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .state(state), .stall(stall), .is_btype(btype), .is_jal(jal), .is_jalr(jalr),
    .take_branch(take), .imm_b(imm_b), .imm_j(imm_j), .imm_u(imm_u), .alu_result(alu), .trap_req(trap),
    .trap_is_irq(irq), .trap_cause(cause), .mret(mret), .mtvec_wr(wr), .mtvec_wdata(wdata), .pc(pc),
    .pc_plus_4(pc_plus_4), .pc_plus_imm(pc_plus_imm), .mepc(mepc), .mcause(mcause), .mtvec(mtvec),
    .misalign_exc(mis));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit idle, stl, b, j, jr, tk, trp, irq, mr, wr;
    logic [4:0] cause;
    logic [31:0] ib, ij, alu, wd;
    logic [31:0] e_pc, e_mepc, e_mc, e_mt;
    bit e_mis;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; btype = 0; jal = 0; jalr = 0; take = 0; trap = 0; irq = 0; mret = 0; wr = 0;
    state = 4; cause = 0; imm_b = 0; imm_j = 0; imm_u = 0; alu = 0; wdata = 0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, e_mepc, e_mc, e_mt, input bit e_mis);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " mepc"}, mepc, e_mepc);
    chk({tag, " mcause"}, mcause, e_mc);
    chk({tag, " mtvec"}, mtvec, e_mt);
    chk({tag, " misalign_exc"}, {31'b0, mis}, {31'b0, e_mis});
    chk({tag, " pc_plus_4"}, pc_plus_4, e_pc + 32'd4);
  endtask

  // behavioural reference state
  logic [31:0] m_pc, m_mepc, m_mcause, m_mtvec;
  bit m_mis;

  function automatic logic [31:0] cur_imm();
    return btype ? imm_b : jal ? imm_j : imm_u;
  endfunction

  task automatic model_step();
    logic [31:0] target, base;
    bit redirect, commit;
    if (rst) begin
      m_pc = 32'h100; m_mepc = 0; m_mcause = 0; m_mtvec = 0; m_mis = 0;
      return;
    end
    commit = (state == 4) && !stall;
    redirect = (btype && take) || jal;
    if (jalr) target = alu - (alu % 2);
    else if (redirect) target = m_pc + cur_imm();
    else target = m_pc + 4;
    base = m_mtvec - (m_mtvec % 4);
    m_mis = 0;
    if (commit) begin
      if (trap) begin
        m_mcause = irq ? (32'h8000_0000 + cause) : 32'(cause);
        m_mepc = irq ? target : m_pc;
        m_pc = (m_mtvec % 2 == 1 && irq) ? base + 4 * cause : base;
      end else if (mret) begin
        m_pc = m_mepc - (m_mepc % 4);
      end else if ((redirect || jalr) && target % 4 != 0) begin
        m_mepc = m_pc; m_mcause = 0; m_pc = base; m_mis = 1;
      end else begin
        m_pc = target;
      end
    end
    if (wr) m_mtvec = wdata - (wdata % 4) + (wdata % 2);
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] v = $urandom & 32'h0000_3FFF;
    if ($urandom_range(0, 7) == 0) v = -v;
    return ($urandom_range(0, 1) == 0) ? (v & ~32'd3) : v;
  endfunction

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h100, 0, 0, 0, 0);
    rst = 0;

    vq.push_back(vec_t'{j:1, ij:'h100, e_pc:'h200, default:0});
    vq.push_back(vec_t'{stl:1, b:1, tk:1, ib:'h10, e_pc:'h200, default:0});
    vq.push_back(vec_t'{b:1, tk:1, ib:'h10, e_pc:'h210, default:0});
    vq.push_back(vec_t'{idle:1, j:1, ij:'h40, e_pc:'h210, default:0});
    vq.push_back(vec_t'{j:1, ij:'hF0, e_pc:'h300, default:0});
    vq.push_back(vec_t'{jr:1, alu:'h401, e_pc:'h400, default:0});
    vq.push_back(vec_t'{j:1, ij:'hFFFF_FF00, e_pc:'h300, default:0});
    vq.push_back(vec_t'{j:1, ij:'h6, e_pc:'h0, e_mepc:'h300, e_mis:1, default:0});
    vq.push_back(vec_t'{idle:1, e_pc:'h0, e_mepc:'h300, default:0});
    vq.push_back(vec_t'{idle:1, wr:1, wd:'h1001, e_pc:'h0, e_mepc:'h300, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{j:1, ij:'h500, e_pc:'h500, e_mepc:'h300, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{trp:1, irq:1, cause:7, e_pc:'h101C, e_mepc:'h504, e_mc:'h8000_0007, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{mr:1, e_pc:'h504, e_mepc:'h504, e_mc:'h8000_0007, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{j:1, ij:'hFFFF_FFFC, e_pc:'h500, e_mepc:'h504, e_mc:'h8000_0007, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{trp:1, cause:7, e_pc:'h1000, e_mepc:'h500, e_mc:'h7, e_mt:'h1001, default:0});
    vq.push_back(vec_t'{trp:1, irq:1, cause:3, wr:1, wd:'h2000, e_pc:'h100C, e_mepc:'h1004, e_mc:'h8000_0003, e_mt:'h2000, default:0});
    vq.push_back(vec_t'{idle:1, wr:1, wd:'hFFFF_FFFF, e_pc:'h100C, e_mepc:'h1004, e_mc:'h8000_0003, e_mt:'hFFFF_FFFD, default:0});
    vq.push_back(vec_t'{trp:1, irq:1, cause:2, wr:1, wd:'h2000, e_pc:'h4, e_mepc:'h1010, e_mc:'h8000_0002, e_mt:'h2000, default:0});
    vq.push_back(vec_t'{trp:1, cause:2, mr:1, j:1, ij:'h2, e_pc:'h2000, e_mepc:'h4, e_mc:'h2, e_mt:'h2000, default:0});
    vq.push_back(vec_t'{mr:1, j:1, ij:'h2, e_pc:'h4, e_mepc:'h4, e_mc:'h2, e_mt:'h2000, default:0});
    vq.push_back(vec_t'{b:1, ib:'h2, e_pc:'h8, e_mepc:'h4, e_mc:'h2, e_mt:'h2000, default:0});
    vq.push_back(vec_t'{jr:1, alu:'h3, e_pc:'h2000, e_mepc:'h8, e_mt:'h2000, e_mis:1, default:0});
    vq.push_back(vec_t'{stl:1, trp:1, irq:1, cause:1, e_pc:'h2000, e_mepc:'h8, e_mt:'h2000, default:0});

    foreach (vq[i]) begin
      clear_inputs();
      state = vq[i].idle ? 4'd2 : 4'd4;
      stall = vq[i].stl; btype = vq[i].b; jal = vq[i].j; jalr = vq[i].jr; take = vq[i].tk;
      trap = vq[i].trp; irq = vq[i].irq; mret = vq[i].mr; wr = vq[i].wr; cause = vq[i].cause;
      imm_b = vq[i].ib; imm_j = vq[i].ij; alu = vq[i].alu; wdata = vq[i].wd;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_mepc, vq[i].e_mc, vq[i].e_mt, vq[i].e_mis);
    end

    // reset wins over a concurrent trapping commit and mtvec write
    clear_inputs();
    rst = 1; trap = 1; irq = 1; cause = 5; wr = 1; wdata = 32'h3000;
    @(posedge clk);
    #1;
    check_all("rst_vs_trap", 32'h100, 0, 0, 0, 0);

    m_pc = 32'h100; m_mepc = 0; m_mcause = 0; m_mtvec = 0; m_mis = 0;
    for (int k = 0; k < 600; k++) begin
      int cls;
      clear_inputs();
      rst = ($urandom_range(0, 59) == 0);
      state = ($urandom_range(0, 3) != 0) ? 4'd4 : 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 6) == 0);
      cls = $urandom_range(0, 3);
      btype = (cls == 1); jal = (cls == 2); jalr = (cls == 3);
      take = $urandom_range(0, 1);
      imm_b = rnd_imm(); imm_j = rnd_imm(); imm_u = rnd_imm();
      alu = $urandom;
      trap = ($urandom_range(0, 5) == 0);
      irq = $urandom_range(0, 1);
      cause = 5'($urandom);
      mret = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      model_step();
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", k), m_pc, m_mepc, m_mcause, m_mtvec, m_mis);
      chk($sformatf("rnd%0d pc_plus_imm", k), pc_plus_imm, m_pc + cur_imm());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
